// File: rtl/pipelined_csel_addsub_if.sv
// ----------------------------------------------------------------------------
// pipelined_csel_addsub_if
//   Operand/result bundle for the pipelined carry-select adder/subtractor.
//   master : operand source / result sink (decode stage + result register)
//   slave  : the adder/subtractor itself
// Signals
//   in_valid  / in_ready   operand-side handshake
//   a, b, c_in, op_sub     operands, carry-in (ADD only), 1 = subtract
//   out_valid / out_ready  result-side handshake
//   sum, carry, overflow, zero  result and flags
// ----------------------------------------------------------------------------
interface pipelined_csel_addsub_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, c_in, op_sub, out_ready,
      input  in_ready, out_valid, sum, carry, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, c_in, op_sub, out_ready,
      output in_ready, out_valid, sum, carry, overflow, zero
   );
endinterface

// File: rtl/pipelined_csel_addsub.sv
// ----------------------------------------------------------------------------
// pipelined_csel_addsub
//   Parametrised pipelined carry-select adder/subtractor for the calculator
//   datapath. Operands are cut into BLOCK-bit groups; each group forms its sum
//   for carry-in 0 and 1 and the incoming carry selects one. A register stage
//   follows every GROUPS_PER_STAGE groups, giving LAT = ceil(NBLK/GPS) stages.
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of pipelined_csel_addsub_if:
//          in_valid/in_ready, a, b, c_in, op_sub (operand side)
//          out_valid/out_ready, sum, carry, overflow, zero (result side)
// ----------------------------------------------------------------------------
module pipelined_csel_addsub #(
   parameter int unsigned WIDTH            = 16,
   parameter int unsigned BLOCK            = 4,
   parameter int unsigned GROUPS_PER_STAGE = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pipelined_csel_addsub_if.slave  bus
);
   localparam int unsigned NBLK = WIDTH / BLOCK;
   localparam int unsigned GPS  = GROUPS_PER_STAGE;
   localparam int unsigned LAT  = (NBLK + GPS - 1) / GPS;
   localparam int unsigned MSB  = WIDTH - 1;

   logic             stall;
   logic             accept;
   logic [WIDTH-1:0] b_eff;
   logic             cin;

   // Stage registers: resolved low sum bits, resolved carry, operands, valid
   logic             st_v   [LAT];
   logic [WIDTH-1:0] st_sum [LAT];
   logic             st_c   [LAT];
   logic [WIDTH-1:0] st_a   [LAT];
   logic [WIDTH-1:0] st_b   [LAT];
   logic             ovf_r;
   logic             zero_r;

   // What each stage sees at its input, and what it resolves
   logic             src_v   [LAT];
   logic [WIDTH-1:0] src_sum [LAT];
   logic             src_c   [LAT];
   logic [WIDTH-1:0] src_a   [LAT];
   logic [WIDTH-1:0] src_b   [LAT];
   logic [WIDTH-1:0] nx_sum  [LAT];
   logic             nx_c    [LAT];
   logic             ovf_nx;
   logic             zero_nx;

   // Only a presented-but-unconsumed result can block the pipeline
   assign stall        = st_v[LAT-1] && !bus.out_ready;
   assign bus.in_ready = !stall;
   assign accept       = bus.in_valid && !stall;

   // Subtraction is A + ~B + 1; c_in is ignored for SUB
   always_comb begin
      b_eff = bus.op_sub ? ~bus.b : bus.b;
      cin   = bus.op_sub ? 1'b1 : bus.c_in;
   end

   // Stage 0 is fed from the operand port, later stages from the previous register
   always_comb begin
      src_v[0]   = accept;
      src_sum[0] = '0;
      src_c[0]   = cin;
      src_a[0]   = bus.a;
      src_b[0]   = b_eff;
      for (int unsigned k = 1; k < LAT; k++) begin
         src_v[k]   = st_v[k-1];
         src_sum[k] = st_sum[k-1];
         src_c[k]   = st_c[k-1];
         src_a[k]   = st_a[k-1];
         src_b[k]   = st_b[k-1];
      end
   end

   // Carry-select chain: stage k resolves groups [k*GPS, min((k+1)*GPS, NBLK))
   always_comb begin
      logic [WIDTH-1:0] s;
      logic             c;
      logic [BLOCK:0]   r0;
      logic [BLOCK:0]   r1;
      logic [BLOCK:0]   r;
      int unsigned      g;
      s  = '0;
      c  = 1'b0;
      r0 = '0;
      r1 = '0;
      r  = '0;
      g  = 0;
      for (int unsigned k = 0; k < LAT; k++) begin
         s = src_sum[k];
         c = src_c[k];
         for (int unsigned j = 0; j < GPS; j++) begin
            g = k * GPS + j;
            if (g < NBLK) begin
               r0 = {1'b0, src_a[k][g*BLOCK +: BLOCK]} + {1'b0, src_b[k][g*BLOCK +: BLOCK]};
               if (g == 0) begin
                  // lowest group adds the true carry-in, no select pair
                  r = r0 + {{BLOCK{1'b0}}, c};
               end else begin
                  r1 = r0 + {{BLOCK{1'b0}}, 1'b1};
                  r  = c ? r1 : r0;
               end
               s[g*BLOCK +: BLOCK] = r[BLOCK-1:0];
               c = r[BLOCK];
            end
         end
         nx_sum[k] = s;
         nx_c[k]   = c;
      end
   end

   // Flags are registered with the result so reset can clear them and they hold
   always_comb begin
      ovf_nx  = (src_a[LAT-1][MSB] == src_b[LAT-1][MSB]) &&
                (nx_sum[LAT-1][MSB] != src_a[LAT-1][MSB]);
      zero_nx = (nx_sum[LAT-1] == '0);
   end

   // Bubbles move the valid bit only; data fields load just for real operations,
   // which keeps the final register (the outputs) unchanged while out_valid=0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < LAT; k++) begin
            st_v[k]   <= 1'b0;
            st_sum[k] <= '0;
            st_c[k]   <= 1'b0;
            st_a[k]   <= '0;
            st_b[k]   <= '0;
         end
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
      end else if (!stall) begin
         for (int unsigned k = 0; k < LAT; k++) begin
            st_v[k] <= src_v[k];
            if (src_v[k]) begin
               st_sum[k] <= nx_sum[k];
               st_c[k]   <= nx_c[k];
               st_a[k]   <= src_a[k];
               st_b[k]   <= src_b[k];
            end
         end
         if (src_v[LAT-1]) begin
            ovf_r  <= ovf_nx;
            zero_r <= zero_nx;
         end
      end
   end

   assign bus.out_valid = st_v[LAT-1];
   assign bus.sum       = st_sum[LAT-1];
   assign bus.carry     = st_c[LAT-1];
   assign bus.overflow  = ovf_r;
   assign bus.zero      = zero_r;

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// ----------------------------------------------------------------------------
// tb_pipelined_csel_addsub
//   Scoreboard bench: the driver pushes the reference result for every
//   accepted operand set; a negedge monitor pops and compares whenever a
//   result is consumed. The reference is plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_pipelined_csel_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BLOCK = 4,
   parameter int unsigned GPS   = 2
);
   localparam int unsigned NBLK = WIDTH / BLOCK;
   localparam int unsigned LAT  = (NBLK + GPS - 1) / GPS;
   localparam longint      HI   = (longint'(1) <<< (WIDTH - 1)) - 1;
   localparam longint      LO   = -(longint'(1) <<< (WIDTH - 1));

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
      logic             zero;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rand_rdy = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned n_out = 0;
   res_t        exp_q[$];
   int unsigned pop_cyc[$];

   pipelined_csel_addsub_if #(.WIDTH(WIDTH)) bus ();

   pipelined_csel_addsub #(
      .WIDTH(WIDTH),
      .BLOCK(BLOCK),
      .GROUPS_PER_STAGE(GPS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic sub);
      res_t         r;
      longint       sa, sb, sr;
      logic [WIDTH:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         r.sum   = a - b;
         r.carry = (a >= b);
         sr      = sa - sb;
      end else begin
         u       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
         r.sum   = u[WIDTH-1:0];
         r.carry = u[WIDTH];
         sr      = sa + sb + longint'(cin);
      end
      r.ovf  = (sr > HI) || (sr < LO);
      r.zero = (r.sum == '0);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: a result is consumed at the edge following a negedge with valid&&ready
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got sum=%0h with no operation outstanding", bus.sum);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            check("result {sum,carry,ovf,zero}",
                  64'({bus.sum, bus.carry, bus.overflow, bus.zero}),
                  64'({e.sum, e.carry, e.ovf, e.zero}));
         end
         pop_cyc.push_back(cyc);
         n_out++;
      end
   end

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
      int unsigned w;
      w = 0;
      bus.a        = a;
      bus.b        = b;
      bus.c_in     = cin;
      bus.op_sub   = sub;
      bus.in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (bus.in_ready) break;
         w++;
         if (w > 200) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", w);
            bus.in_valid = 1'b0;
            return;
         end
      end
      exp_q.push_back(model(a, b, cin, sub));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int unsigned w;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         tick(1);
         w++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [WIDTH-1:0] rnd_val();
      logic [WIDTH-1:0] v;
      case ($urandom_range(0, 5))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b0, {(WIDTH-1){1'b1}}};
         3:       v = {1'b1, {(WIDTH-1){1'b0}}};
         default: v = WIDTH'($urandom);
      endcase
      return v;
   endfunction

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_sum"},       64'(bus.sum),       64'd0);
      check({tag, "_carry"},     64'(bus.carry),     64'd0);
      check({tag, "_overflow"},  64'(bus.overflow),  64'd0);
      check({tag, "_zero"},      64'(bus.zero),      64'd0);
   endtask

   logic [WIDTH-1:0] da [8];
   logic [WIDTH-1:0] db [8];
   logic             dc [8];
   logic             ds [8];

   initial begin
      int unsigned      lat_edges;
      int unsigned      n0;
      logic [WIDTH+3:0] snap;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.c_in      = 1'b0;
      bus.op_sub    = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      tick(2);
      check_reset_state("reset");
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      rst_n = 1'b1;
      tick(1);

      // Group-boundary add and accept-to-valid latency
      issue(WIDTH'(16'h000F), WIDTH'(16'h0001), 1'b0, 1'b0);
      lat_edges = 1;
      while (!bus.out_valid && lat_edges < 20) begin
         tick(1);
         lat_edges++;
      end
      check("latency_edges", 64'(lat_edges), 64'(LAT));
      drain("drain_latency");

      // Directed corner vectors
      da[0] = '1;                        db[0] = WIDTH'(1); dc[0] = 1'b0; ds[0] = 1'b0;
      da[1] = {1'b0, {(WIDTH-1){1'b1}}}; db[1] = WIDTH'(1); dc[1] = 1'b0; ds[1] = 1'b0;
      da[2] = WIDTH'(5);                 db[2] = WIDTH'(7); dc[2] = 1'b1; ds[2] = 1'b1;
      da[3] = {1'b1, {(WIDTH-1){1'b0}}}; db[3] = WIDTH'(1); dc[3] = 1'b0; ds[3] = 1'b1;
      da[4] = WIDTH'(3);                 db[4] = WIDTH'(4); dc[4] = 1'b1; ds[4] = 1'b0;
      da[5] = WIDTH'(5);                 db[5] = WIDTH'(5); dc[5] = 1'b0; ds[5] = 1'b1;
      da[6] = '0;                        db[6] = '0;        dc[6] = 1'b0; ds[6] = 1'b0;
      da[7] = '1;                        db[7] = '1;        dc[7] = 1'b1; ds[7] = 1'b0;
      for (int i = 0; i < 8; i++) issue(da[i], db[i], dc[i], ds[i]);
      drain("drain_directed");

      // Back-to-back random ops: 8 results on consecutive cycles
      pop_cyc.delete();
      for (int i = 0; i < 8; i++)
         issue(rnd_val(), rnd_val(), 1'($urandom), 1'($urandom));
      drain("drain_b2b");
      check("b2b_count", 64'(pop_cyc.size()), 64'd8);
      if (pop_cyc.size() == 8)
         check("b2b_span_cycles", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

      // Stall with full pipeline: outputs and in_ready frozen, inputs ignored
      n0 = n_out;
      bus.out_ready = 1'b0;
      for (int i = 0; i < int'(LAT); i++)
         issue(rnd_val(), rnd_val(), 1'($urandom), 1'($urandom));
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      snap = {bus.sum, bus.carry, bus.overflow, bus.zero, bus.out_valid};
      for (int i = 0; i < 5; i++) begin
         bus.a      = rnd_val();
         bus.b      = rnd_val();
         bus.op_sub = 1'($urandom);
         bus.c_in   = 1'($urandom);
         tick(1);
         check("stall_hold", 64'({bus.sum, bus.carry, bus.overflow, bus.zero, bus.out_valid}),
               64'(snap));
         check("stall_in_ready_hold", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      drain("drain_stall");
      check("stall_result_count", 64'(n_out - n0), 64'(LAT));

      // Reset with operations in flight: discarded, nothing stale afterwards
      bus.out_ready = 1'b0;
      for (int i = 0; i < ((LAT < 2) ? int'(LAT) : 2); i++)
         issue(rnd_val(), rnd_val(), 1'($urandom), 1'($urandom));
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      exp_q.delete();
      check_reset_state("midreset");
      n0 = n_out;
      bus.out_ready = 1'b1;
      tick(10);
      check("no_stale_after_reset", 64'(n_out - n0), 64'd0);

      // Long random run with random backpressure and input gaps
      n0 = n_out;
      rand_rdy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         issue(rnd_val(), rnd_val(), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) tick(1);
      end
      rand_rdy = 1'b0;
      tick(1);
      bus.out_ready = 1'b1;
      drain("drain_random");
      check("random_result_count", 64'(n_out - n0), 64'd200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
